// File: rtl/v74x148_irq.sv
// Clocked 8-input priority encoder with a pending-request latch and a valid/ack handshake.
// Optional round-robin selection is enabled by defining V74X148_IRQ_ROTATE_EN.
module v74x148_irq #(
    parameter int unsigned CODE_W = 3,
    localparam int unsigned N = 2 ** CODE_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EI_L,
    input  logic [N-1:0]      I_L,
    input  logic              ACK,
    output logic [CODE_W-1:0] A_L,
    output logic              GS_L,
    output logic              VALID,
    output logic              EO_L,
    output logic [N-1:0]      PEND
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] code_nxt;
    logic              valid_nxt;
    logic [CODE_W-1:0] a_l_nxt;
    logic              eo_l_nxt;
    logic [N-1:0]      pend_nxt;
    logic [N-1:0]      req_c;
    logic [N-1:0]      clr_c;
    logic              ack_c;
    logic [CODE_W-1:0] start_idle_c;
    logic [CODE_W-1:0] start_ack_c;

    // First set bit found searching downward from start, wrapping at index 0.
    function automatic logic [CODE_W-1:0] prio(input logic [N-1:0] vec,
                                                input logic [CODE_W-1:0] start);
        logic [CODE_W-1:0] idx;
        logic [CODE_W-1:0] sel;
        sel = '0;
        for (int j = N - 1; j >= 0; j--) begin
            idx = start - CODE_W'(j);
            if (vec[idx]) sel = idx;
        end
        return sel;
    endfunction

`ifdef V74X148_IRQ_ROTATE_EN
    // rot remembers the last served index; the search starts just below it.
    logic [CODE_W-1:0] rot;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rot <= '0;
        end else if (ack_c) begin
            rot <= code;
        end
    end

    assign start_idle_c = rot - CODE_W'(1);
    assign start_ack_c  = code - CODE_W'(1);
`else
    assign start_idle_c = '1;
    assign start_ack_c  = '1;
`endif

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            code  <= '0;
            VALID <= 1'b0;
            A_L   <= '1;
            GS_L  <= 1'b1;
            EO_L  <= 1'b1;
            PEND  <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            VALID <= valid_nxt;
            A_L   <= a_l_nxt;
            GS_L  <= ~valid_nxt;
            EO_L  <= eo_l_nxt;
            PEND  <= pend_nxt;
        end
    end

    // Capture, clear, next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        valid_nxt = VALID;
        req_c     = EI_L ? '0 : ~I_L;
        ack_c     = VALID & ACK;
        clr_c     = ack_c ? (N'(1) << code) : '0;
        // Set wins over clear so a held request re-pends immediately.
        pend_nxt  = (PEND & ~clr_c) | req_c;

        case (state)
            S_IDLE: begin
                if (|PEND) begin
                    code_nxt  = prio(PEND, start_idle_c);
                    valid_nxt = 1'b1;
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ACK) begin
                    if (|pend_nxt) begin
                        code_nxt = prio(pend_nxt, start_ack_c);
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        a_l_nxt  = valid_nxt ? ~code_nxt : '1;
        eo_l_nxt = ~(~EI_L & (&I_L) & ~(|PEND) & ~valid_nxt);
    end

endmodule

// File: tb/tb_v74x148_irq.sv
// Directed self-checking bench for v74x148_irq (default CODE_W = 3).
module tb_v74x148_irq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EI_L;
    logic [7:0] I_L;
    logic       ACK;
    logic [2:0] A_L;
    logic       GS_L;
    logic       VALID;
    logic       EO_L;
    logic [7:0] PEND;

    int tests  = 0;
    int failed = 0;

    v74x148_irq dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EI_L  (EI_L),
        .I_L   (I_L),
        .ACK   (ACK),
        .A_L   (A_L),
        .GS_L  (GS_L),
        .VALID (VALID),
        .EO_L  (EO_L),
        .PEND  (PEND)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; EI_L = 1'b0; I_L = 8'hFF; ACK = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", VALID); end
        tests++; if (A_L !== 3'b111) begin failed++; $display("FAIL rst_a_l got %b exp 111", A_L); end
        tests++; if (GS_L !== 1'b1) begin failed++; $display("FAIL rst_gs_l got %b exp 1", GS_L); end
        tests++; if (EO_L !== 1'b1) begin failed++; $display("FAIL rst_eo_l got %b exp 1", EO_L); end
        tests++; if (PEND !== 8'h00) begin failed++; $display("FAIL rst_pend got %h exp 00", PEND); end
    endtask

    task automatic test_encode();
        do_reset();
        I_L = 8'b1101_0111;
        tick();
        tests++; if (PEND !== 8'h28) begin failed++; $display("FAIL enc_pend got %h exp 28", PEND); end
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL enc_valid0 got %b exp 0", VALID); end
        I_L = 8'hFF;
        tick();
        tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL enc_valid1 got %b exp 1", VALID); end
        tests++; if (A_L !== 3'b010) begin failed++; $display("FAIL enc_code5 got %b exp 010", A_L); end
        tests++; if (GS_L !== 1'b0) begin failed++; $display("FAIL enc_gs_l got %b exp 0", GS_L); end
        tests++; if (EO_L !== 1'b1) begin failed++; $display("FAIL enc_eo_busy got %b exp 1", EO_L); end
        ACK = 1'b1;
        tick();
        tests++; if (A_L !== 3'b100) begin failed++; $display("FAIL enc_code3 got %b exp 100", A_L); end
        tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL enc_b2b_valid got %b exp 1", VALID); end
        tests++; if (PEND !== 8'h08) begin failed++; $display("FAIL enc_pend3 got %h exp 08", PEND); end
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL enc_drop got %b exp 0", VALID); end
        tests++; if (A_L !== 3'b111) begin failed++; $display("FAIL enc_a_idle got %b exp 111", A_L); end
        tests++; if (PEND !== 8'h00) begin failed++; $display("FAIL enc_pend0 got %h exp 00", PEND); end
        ACK = 1'b0;
        tick();
        tests++; if (EO_L !== 1'b0) begin failed++; $display("FAIL enc_eo_l got %b exp 0", EO_L); end
        tests++; if (GS_L !== 1'b1) begin failed++; $display("FAIL enc_gs_idle got %b exp 1", GS_L); end
    endtask

    task automatic test_no_preempt();
        do_reset();
        I_L = 8'hF7;
        tick();
        I_L = 8'hFF;
        tick();
        tests++; if (A_L !== 3'b100) begin failed++; $display("FAIL np_code3 got %b exp 100", A_L); end
        I_L = 8'h7F;
        tick();
        tests++; if (A_L !== 3'b100) begin failed++; $display("FAIL np_hold1 got %b exp 100", A_L); end
        tests++; if (PEND !== 8'h88) begin failed++; $display("FAIL np_pend got %h exp 88", PEND); end
        tick();
        tests++; if (A_L !== 3'b100) begin failed++; $display("FAIL np_hold2 got %b exp 100", A_L); end
        I_L = 8'hFF; ACK = 1'b1;
        tick();
        tests++; if (A_L !== 3'b000) begin failed++; $display("FAIL np_code7 got %b exp 000", A_L); end
        tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL np_valid got %b exp 1", VALID); end
        tests++; if (PEND !== 8'h80) begin failed++; $display("FAIL np_pend7 got %h exp 80", PEND); end
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL np_drop got %b exp 0", VALID); end
        ACK = 1'b0;
    endtask

    task automatic test_hold_ack();
        do_reset();
        I_L = 8'hFB; ACK = 1'b1;
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL hold_ack_ignored got %b exp 0", VALID); end
        tests++; if (PEND !== 8'h04) begin failed++; $display("FAIL hold_pend0 got %h exp 04", PEND); end
        tick();
        tests++; if (A_L !== 3'b101) begin failed++; $display("FAIL hold_first got %b exp 101", A_L); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL hold_valid[%0d] got %b exp 1", i, VALID); end
            tests++; if (A_L !== 3'b101) begin failed++; $display("FAIL hold_code[%0d] got %b exp 101", i, A_L); end
            tests++; if (PEND !== 8'h04) begin failed++; $display("FAIL hold_pend[%0d] got %h exp 04", i, PEND); end
        end
        I_L = 8'hFF;
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL hold_release got %b exp 0", VALID); end
        tests++; if (PEND !== 8'h00) begin failed++; $display("FAIL hold_pend_clr got %h exp 00", PEND); end
        ACK = 1'b0;
    endtask

    task automatic test_mask();
        do_reset();
        I_L = 8'hFE;
        tick();
        EI_L = 1'b1; I_L = 8'h00;
        tick();
        tests++; if (PEND !== 8'h01) begin failed++; $display("FAIL mask_pend got %h exp 01", PEND); end
        tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL mask_valid got %b exp 1", VALID); end
        tests++; if (A_L !== 3'b111) begin failed++; $display("FAIL mask_code0 got %b exp 111", A_L); end
        tests++; if (GS_L !== 1'b0) begin failed++; $display("FAIL mask_gs_l got %b exp 0", GS_L); end
        tests++; if (EO_L !== 1'b1) begin failed++; $display("FAIL mask_eo_l got %b exp 1", EO_L); end
        tick();
        tests++; if (PEND !== 8'h01) begin failed++; $display("FAIL mask_pend_hold got %h exp 01", PEND); end
        ACK = 1'b1;
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL mask_ack got %b exp 0", VALID); end
        tests++; if (PEND !== 8'h00) begin failed++; $display("FAIL mask_pend_clr got %h exp 00", PEND); end
        tests++; if (EO_L !== 1'b1) begin failed++; $display("FAIL mask_eo_idle got %b exp 1", EO_L); end
        ACK = 1'b0; EI_L = 1'b0; I_L = 8'hFF;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_a;
        do_reset();
        I_L = 8'h3F;
        tick();
        tick();
        tests++; if (A_L !== 3'b000) begin failed++; $display("FAIL b2b_first got %b exp 000", A_L); end
        ACK = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef V74X148_IRQ_ROTATE_EN
            exp_a = (i % 2 == 0) ? 3'b001 : 3'b000;
`else
            exp_a = 3'b000;
`endif
            tests++; if (A_L !== exp_a) begin failed++; $display("FAIL b2b_code[%0d] got %b exp %b", i, A_L, exp_a); end
            tests++; if (VALID !== 1'b1) begin failed++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, VALID); end
        end
        ACK = 1'b0; I_L = 8'hFF;
    endtask

    task automatic test_reset_mid();
        do_reset();
        I_L = 8'hDF;
        tick();
        I_L = 8'hFF;
        tick();
        tests++; if (A_L !== 3'b010) begin failed++; $display("FAIL rmid_pre got %b exp 010", A_L); end
        RESET = 1'b1; ACK = 1'b1; I_L = 8'h00;
        tick();
        tests++; if (VALID !== 1'b0) begin failed++; $display("FAIL rmid_valid got %b exp 0", VALID); end
        tests++; if (A_L !== 3'b111) begin failed++; $display("FAIL rmid_a_l got %b exp 111", A_L); end
        tests++; if (GS_L !== 1'b1) begin failed++; $display("FAIL rmid_gs_l got %b exp 1", GS_L); end
        tests++; if (PEND !== 8'h00) begin failed++; $display("FAIL rmid_pend got %h exp 00", PEND); end
        tests++; if (EO_L !== 1'b1) begin failed++; $display("FAIL rmid_eo_l got %b exp 1", EO_L); end
        RESET = 1'b0; ACK = 1'b0; I_L = 8'hFF;
    endtask

    initial begin
        RESET = 1'b1; EI_L = 1'b0; I_L = 8'hFF; ACK = 1'b0;
        test_reset();
        test_encode();
        test_no_preempt();
        test_hold_ack();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
